// File: rtl/dma_rd_burst_if.sv
// Signal bundle for dma_rd_burst. The slave modport is the DMA engine's side.
// The master modport is the environment's side: job source, read fabric and RAM.
interface dma_rd_burst_if #(
  parameter int AXI_DW = 128
) ();
  localparam int B = AXI_DW / 8;

  logic              cfg_valid;
  logic              cfg_ready;
  logic [31:0]       cfg_src_sa;
  logic [31:0]       cfg_dst_sa;
  logic [31:0]       cfg_len;
  logic              dmar_valid;
  logic              dmar_ready;
  logic [31:0]       dmar_sa;
  logic [31:0]       dmar_len;
  logic [AXI_DW-1:0] dma_rdata;
  logic              dma_rlast;
  logic              dma_rvalid;
  logic              dma_rready;
  logic              ram_we;
  logic [B-1:0]      ram_be;
  logic [31:0]       ram_a;
  logic [AXI_DW-1:0] ram_d;
  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  cfg_valid, cfg_src_sa, cfg_dst_sa, cfg_len,
    output cfg_ready,
    output dmar_valid, dmar_sa, dmar_len,
    input  dmar_ready,
    input  dma_rdata, dma_rlast, dma_rvalid,
    output dma_rready,
    output ram_we, ram_be, ram_a, ram_d,
    output busy, done, err
  );

  modport master (
    output cfg_valid, cfg_src_sa, cfg_dst_sa, cfg_len,
    input  cfg_ready,
    input  dmar_valid, dmar_sa, dmar_len,
    output dmar_ready,
    output dma_rdata, dma_rlast, dma_rvalid,
    input  dma_rready,
    input  ram_we, ram_be, ram_a, ram_d,
    input  busy, done, err
  );
endinterface

// File: rtl/dma_rd_burst.sv
// Read DMA: splits a job into 4 KB-safe bursts, buffers returned beats in a FIFO
// sized by outstanding-beat credit, and streams them to RAM with byte enables.
module dma_rd_burst #(
  parameter int AXI_DW    = 128,
  parameter int FF_AW     = 4,
  parameter int MAX_BEATS = 16
) (
  input  logic           usr_clk,
  input  logic           usr_reset_n,
  dma_rd_burst_if.slave  bus
);
  localparam int B     = AXI_DW / 8;
  localparam int LOG2B = $clog2(B);
  localparam int D     = 1 << FF_AW;
  localparam int CW    = FF_AW + 1;
  localparam int PW    = 12 - LOG2B;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;

  state_t            r_state, w_state_nxt;
  logic [AXI_DW-1:0] r_mem [D];
  logic [CW-1:0]     r_wp, r_rp, r_out_cnt;
  logic [31:0]       r_src, r_dst, r_rem_req, r_rem_wr;
  logic [LOG2B-1:0]  r_tail;
  logic              r_dmar_valid;
  logic [31:0]       r_dmar_sa, r_dmar_len, r_dmar_beats;
  logic [PW-1:0]     r_rx_blk;
  logic [31:0]       r_rx_rem;
  logic [8:0]        r_rx_idx;
  logic              r_ram_we;
  logic [B-1:0]      r_ram_be;
  logic [31:0]       r_ram_a;
  logic [AXI_DW-1:0] r_ram_d;
  logic              r_done, r_err;

  logic [CW-1:0]     w_count;
  logic              w_full, w_empty, w_push, w_pop, w_in_job;
  logic              w_cfg_hs, w_req_hs, w_last_wr, w_rx_last_exp, w_done_set;
  logic [31:0]       w_to4k, w_beats, w_space, w_cfg_beats, w_align_mask;
  logic [B-1:0]      w_tail_be;

  assign w_count      = r_wp - r_rp;
  assign w_full       = (w_count == CW'(D));
  assign w_empty      = (w_count == '0);
  assign w_in_job     = (r_state != S_IDLE);
  // Beats accepted while idle (after an abort) are taken off the bus but dropped.
  assign w_push       = bus.dma_rvalid && !w_full && w_in_job;
  assign w_pop        = !w_empty;
  assign w_cfg_hs     = bus.cfg_valid && (r_state == S_IDLE);
  assign w_req_hs     = r_dmar_valid && bus.dmar_ready;
  assign w_last_wr    = w_pop && (r_rem_wr == 32'd1);
  assign w_to4k       = (32'd4096 - {20'd0, r_src[11:0]}) >> LOG2B;
  assign w_space      = 32'(D) - 32'(w_count) - 32'(r_out_cnt);
  assign w_cfg_beats  = (bus.cfg_len >> LOG2B) + {31'd0, |bus.cfg_len[LOG2B-1:0]};
  assign w_align_mask = ~32'(B - 1);
  assign w_tail_be    = (B'(1) << r_tail) - B'(1);
  // Burst boundaries are deterministic, so the receive side re-derives them.
  assign w_rx_last_exp = (r_rx_rem == 32'd1) || (r_rx_idx == 9'(MAX_BEATS - 1)) || (&r_rx_blk);

  always_comb begin
    w_beats = 32'(MAX_BEATS);
    if (r_rem_req < w_beats) w_beats = r_rem_req;
    if (w_to4k < w_beats)    w_beats = w_to4k;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_done_set  = 1'b0;
    case (r_state)
      S_IDLE: if (bus.cfg_valid) begin
        if (bus.cfg_len != 32'd0) w_state_nxt = S_REQ;
        else                      w_done_set  = 1'b1;
      end
      S_REQ:   if (w_req_hs && (r_rem_req == r_dmar_beats)) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_last_wr) begin
        w_state_nxt = S_IDLE;
        w_done_set  = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge usr_clk) begin
    if (!usr_reset_n) r_state <= S_IDLE;
    else              r_state <= w_state_nxt;
  end

  // NOTE: the buffer storage is deliberately not reset; the pointers define what is valid.
  always_ff @(posedge usr_clk) begin
    if (w_push) r_mem[r_wp[FF_AW-1:0]] <= bus.dma_rdata;
  end

  always_ff @(posedge usr_clk) begin
    if (!usr_reset_n) begin
      r_wp <= '0;          r_rp <= '0;           r_out_cnt <= '0;
      r_src <= '0;         r_dst <= '0;          r_rem_req <= '0;
      r_rem_wr <= '0;      r_tail <= '0;         r_dmar_valid <= 1'b0;
      r_dmar_sa <= '0;     r_dmar_len <= '0;     r_dmar_beats <= '0;
      r_rx_blk <= '0;      r_rx_rem <= '0;       r_rx_idx <= '0;
      r_ram_we <= 1'b0;    r_ram_be <= '0;       r_ram_a <= '0;
      r_ram_d <= '0;       r_done <= 1'b0;       r_err <= 1'b0;
    end else begin
      r_done <= w_done_set;

      if ((r_state == S_REQ) && !r_dmar_valid && (w_space >= w_beats)) begin
        r_dmar_valid <= 1'b1;
        r_dmar_sa    <= r_src;
        r_dmar_len   <= w_beats << LOG2B;
        r_dmar_beats <= w_beats;
      end else if (w_req_hs) begin
        r_dmar_valid <= 1'b0;
        r_src        <= r_src + r_dmar_len;
        r_rem_req    <= r_rem_req - r_dmar_beats;
      end

      r_out_cnt <= r_out_cnt + (w_req_hs ? CW'(r_dmar_beats) : CW'(0)) - (w_push ? CW'(1) : CW'(0));

      if (w_push) begin
        r_wp <= r_wp + CW'(1);
        if (r_rx_rem != 32'd0) begin
          if (bus.dma_rlast != w_rx_last_exp) r_err <= 1'b1;
          r_rx_idx <= w_rx_last_exp ? 9'd0 : r_rx_idx + 9'd1;
          r_rx_blk <= r_rx_blk + PW'(1);
          r_rx_rem <= r_rx_rem - 32'd1;
        end
      end

      r_ram_we <= w_pop;
      if (w_pop) begin
        r_rp     <= r_rp + CW'(1);
        r_ram_a  <= r_dst;
        r_dst    <= r_dst + 32'(B);
        r_ram_d  <= r_mem[r_rp[FF_AW-1:0]];
        r_ram_be <= (w_last_wr && (r_tail != '0)) ? w_tail_be : {B{1'b1}};
        r_rem_wr <= r_rem_wr - 32'd1;
      end

      if (w_cfg_hs) begin
        r_src     <= bus.cfg_src_sa & w_align_mask;
        r_dst     <= bus.cfg_dst_sa & w_align_mask;
        r_rem_req <= w_cfg_beats;
        r_rem_wr  <= w_cfg_beats;
        r_tail    <= bus.cfg_len[LOG2B-1:0];
        r_rx_blk  <= bus.cfg_src_sa[11:LOG2B];
        r_rx_rem  <= w_cfg_beats;
        r_rx_idx  <= '0;
        r_err     <= 1'b0;
      end
    end
  end

  assign bus.cfg_ready  = (r_state == S_IDLE);
  assign bus.busy       = w_in_job;
  assign bus.dmar_valid = r_dmar_valid;
  assign bus.dmar_sa    = r_dmar_sa;
  assign bus.dmar_len   = r_dmar_len;
  assign bus.dma_rready = !w_full;
  assign bus.ram_we     = r_ram_we;
  assign bus.ram_be     = r_ram_be;
  assign bus.ram_a      = r_ram_a;
  assign bus.ram_d      = r_ram_d;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
endmodule

// File: doc/dma_rd_burst.md
DMA_RD_BURST -- requirements
Module: dma_rd_burst

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- AXI_DW, 128, data bus width in bits; B = AXI_DW/8 bytes per beat, power of two >= 4.
- FF_AW, 4, buffer FIFO address width; depth D = 2^FF_AW beats.
- MAX_BEATS, 16, maximum beats per issued burst; 1..256, MAX_BEATS <= D.
REQ-002 Ports, one per line (name, direction, width, meaning):
- usr_clk, in, 1, single clock.
- usr_reset_n, in, 1, synchronous active-low reset.
- cfg_valid / cfg_ready, in / out, 1 each, job handshake.
- cfg_src_sa, cfg_dst_sa, cfg_len, in, 32 each, external source byte address, RAM destination byte address, byte count.
- dmar_valid / dmar_ready, out / in, 1 each, burst request handshake.
- dmar_sa, dmar_len, out, 32 each, burst byte address and burst byte length.
- dma_rdata, in, AXI_DW, read data.
- dma_rlast, dma_rvalid, in, 1 each, last-beat flag and data valid.
- dma_rready, out, 1, data ready.
- ram_we, out, 1, RAM write enable.
- ram_be, out, B, RAM byte enables.
- ram_a, out, 32, RAM byte address.
- ram_d, out, AXI_DW, RAM write data.
- busy, done, err, out, 1 each: job active, one-cycle completion pulse, sticky protocol error.

Function
REQ-003 cfg_src_sa and cfg_dst_sa SHALL be B-aligned; low log2(B) bits SHALL be ignored (treated as zero).
REQ-004 Total beats N = ceil(cfg_len/B); the tail byte count T = cfg_len mod B (T=0 means full beat).
REQ-005 FSM states SHALL be IDLE, REQ, DRAIN; cfg_ready=1 only in IDLE; busy=1 in REQ and DRAIN.
REQ-006 IDLE->REQ on cfg_valid&cfg_ready with cfg_len!=0; cfg_len==0 handshake SHALL stay IDLE and pulse done the next cycle, issuing no request.
REQ-007 Each burst beat count SHALL be min(MAX_BEATS, remaining beats, beats to next 4 KB source boundary); dmar_sa = current source address, dmar_len = beats*B.
REQ-008 dmar_valid SHALL assert in REQ only when D - fifo_count - outstanding_beats >= burst beats; once asserted, dmar_valid, dmar_sa and dmar_len SHALL hold stable until dmar_ready.
REQ-009 Outstanding beat credit SHALL increase by burst beats on request handshake and decrease by 1 per accepted data beat, same-cycle events combined.
REQ-010 REQ->DRAIN on handshake of the burst covering the final beat; DRAIN->IDLE when the final RAM write is issued, with done=1 in that IDLE-entry cycle.
REQ-011 dma_rready = !fifo_full; a beat is accepted on dma_rvalid&dma_rready and written into the FIFO.
REQ-012 FIFO SHALL be popped whenever non-empty; ram_we/ram_a/ram_d/ram_be SHALL be registered and valid the cycle after pop; minimum latency from data acceptance to ram_we is 2 cycles.
REQ-013 ram_a SHALL start at cfg_dst_sa and increment by B per write, wrapping modulo 2^32; ram_be = all ones except on the final beat when T!=0, where ram_be = (1<<T)-1.
REQ-014 err SHALL set when dma_rlast is 1 on a non-final beat of a burst, or 0 on its final beat; err SHALL clear on the next cfg handshake; beat counting SHALL follow expected lengths regardless.
REQ-015 Simultaneous FIFO push and pop SHALL both occur; pop on empty and push on full SHALL never happen.

Reset
REQ-016 With usr_reset_n=0 at a usr_clk edge, all state including mid-job state SHALL return to IDLE with the FIFO emptied; cfg_ready=1, and dmar_valid, dma_rready's internal full flag, ram_we, ram_be, ram_a, ram_d, busy, done and err SHALL be 0 (dma_rready=1).
REQ-017 Data beats arriving after a mid-job reset SHALL be accepted and discarded while in IDLE.

Verification (AXI_DW=128, FF_AW=4, MAX_BEATS=16)
REQ-018 src 0x1000, dst 0x0, len 64 -> one request sa 0x1000 len 64; four ram writes at 0x0,0x10,0x20,0x30, be 0xFFFF; done once.
REQ-019 src 0x0FC0, len 0x100 -> requests (0x0FC0, 0x40) then (0x1000, 0xC0); 16 RAM writes.
REQ-020 len 20 -> request len 32; second write be=0x000F.
REQ-021 len 0 -> done next cycle, dmar_valid never asserted.
REQ-022 len 0x400, dma_rvalid withheld -> at most 16 beats requested until data returns; dmar_ready low 10 cycles holds request stable.
REQ-023 dma_rlast=1 on beat 2 of a 4-beat burst -> err=1; job still completes with 4 writes; reset mid-job -> IDLE, outputs 0 next cycle.
